spi_frame_sched: RTL and testbench



---
 rtl/spi_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/spi_frame_sched.sv | 146 ++++++++++++++
 tb/tb_spi_frame_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared widths and FSM encoding for the SPI frame scheduler.
package spi_pkg;
  localparam int FRAME_W  = 16;
  localparam int HDR_W    = 4;
  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [HDR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [HDR_W-1:0] o_idx,
  output logic             o_valid
);

  // Each requester's distance from the pointer; the smallest distance wins.
  always_comb begin
    int w_best;
    int w_dist;
    w_best  = N_REQ;
    w_dist  = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N_REQ - int'(i_ptr));
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_idx   = HDR_W'(i);
        o_valid = 1'b1;
      end
    end
    o_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_grant[i] = o_valid && (o_idx == HDR_W'(i));
    end
  end

endmodule

// File: rtl/spi_frame_sched.sv
// Round-robin SPI frame sequencer: latches {channel, sample} from the winner and shifts it out MSB first.
module spi_frame_sched
  import spi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic                      clk,
  input  logic                      rst_a,
  input  logic                      ena,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*SAMPLE_W-1:0] data,
  output logic [N_REQ-1:0]          ack,
  output logic                      cs_n,
  output logic                      sclk_n,
  output logic                      mosi,
  output logic                      busy,
  output logic [HDR_W-1:0]          cur_ch,
  output state_t                    dbg_state
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [HDR_W-1:0] PTR_LAST = HDR_W'(N_REQ - 1);
  localparam logic [3:0]       BIT_MSB  = 4'(FRAME_W - 1);

  state_t               r_state;
  logic [HDR_W-1:0]     r_ptr;
  logic [FRAME_W-1:0]   r_frame;
  logic [DIV_W-1:0]     r_div;
  logic [GAP_W-1:0]     r_gap;
  logic [3:0]           r_bit;
  logic [N_REQ-1:0]     r_ack;
  logic                 r_cs_n;
  logic                 r_sclk_n;
  logic                 r_mosi;
  logic                 r_busy;
  logic [HDR_W-1:0]     r_cur_ch;

  logic [N_REQ-1:0]     w_grant;
  logic [HDR_W-1:0]     w_idx;
  logic                 w_valid;
  logic [SAMPLE_W-1:0]  w_sample;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_sample = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_sample = data[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Handshake: req[i] is a level request that must hold with its data until
  // ack[i]; ack is a one-enabled-cycle pulse marking the cycle data was taken.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_frame  <= '0;
      r_div    <= '0;
      r_gap    <= '0;
      r_bit    <= '0;
      r_ack    <= '0;
      r_cs_n   <= 1'b1;
      r_sclk_n <= 1'b1;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_cur_ch <= '0;
    end else if (ena) begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_frame  <= {w_idx, w_sample};
            r_ack    <= w_grant;
            r_cs_n   <= 1'b0;
            r_mosi   <= w_idx[HDR_W-1];
            r_cur_ch <= w_idx;
            r_busy   <= 1'b1;
            r_ptr    <= (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;
            r_div    <= '0;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_div == DIV_LAST) begin
            r_div    <= '0;
            r_sclk_n <= 1'b0;
            r_bit    <= BIT_MSB;
            r_state  <= ST_SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_SHIFT: begin
          // r_sclk_n doubles as the half-bit phase: low = first half of the bit.
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!r_sclk_n) begin
              r_sclk_n <= 1'b1;
              if (r_bit != 4'd0) r_mosi <= r_frame[r_bit - 4'd1];
            end else if (r_bit == 4'd0) begin
              r_cs_n  <= 1'b1;
              r_mosi  <= 1'b0;
              r_gap   <= '0;
              r_state <= ST_GAP;
            end else begin
              r_sclk_n <= 1'b0;
              r_bit    <= r_bit - 4'd1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign cs_n      = r_cs_n;
  assign sclk_n    = r_sclk_n;
  assign mosi      = r_mosi;
  assign busy      = r_busy;
  assign cur_ch    = r_cur_ch;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_frame_sched.sv
// Randomized bench for spi_frame_sched: enabled-cycle reference model, SPI pin decoder and scoreboard.
module tb_spi_frame_sched;
  localparam int N_REQ   = 4;
  localparam int DIV     = 4;
  localparam int GAP     = 2;
  localparam int SW      = 12;
  localparam int LOW_CYC = 33 * DIV;

  logic                 clk = 1'b0;
  logic                 rst_a = 1'b1;
  logic                 ena = 1'b1;
  logic [N_REQ-1:0]     req = '0;
  logic [N_REQ*SW-1:0]  data = '0;
  logic [N_REQ-1:0]     ack;
  logic                 cs_n;
  logic                 sclk_n;
  logic                 mosi;
  logic                 busy;
  logic [3:0]           cur_ch;
  logic [1:0]           dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_frame_sched #(.N_REQ(N_REQ), .DIV(DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .ena       (ena),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .cs_n      (cs_n),
    .sclk_n    (sclk_n),
    .mosi      (mosi),
    .busy      (busy),
    .cur_ch    (cur_ch),
    .dbg_state (dbg_state)
  );

  typedef struct {
    bit full;
    int low_clk;
  } end_t;

  logic [15:0] exp_q[$];
  end_t        end_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is 33*DIV enabled cycles of cs_n low, then GAP
  // enabled cycles before idle; arbitration is a plain wrapping scan.
  bit               m_active = 0;
  int               m_t = 0;
  int               m_clk = 0;
  logic [3:0]       m_ptr = '0;
  logic [3:0]       m_cur = '0;
  logic [N_REQ-1:0] m_ack = '0;
  logic             m_cs_n = 1'b1;
  logic             m_busy = 1'b0;
  bit               m_en_last = 0;
  bit               m_rst_last = 0;

  always @(posedge clk) begin
    int w;
    int c;
    m_en_last  = ena;
    m_rst_last = rst_a;
    if (m_active) m_clk++;
    if (rst_a) begin
      if (m_active && (m_t < LOW_CYC)) begin
        void'(exp_q.pop_back());
        end_q.push_back('{1'b0, m_clk});
      end
      m_active = 0;
      m_cs_n   = 1'b1;
      m_busy   = 1'b0;
      m_ack    = '0;
      m_ptr    = '0;
      m_cur    = '0;
    end else if (ena) begin
      m_ack = '0;
      if (m_active) begin
        m_t++;
        if (m_t == LOW_CYC) begin
          m_cs_n = 1'b1;
          end_q.push_back('{1'b1, m_clk});
        end
        if (m_t == LOW_CYC + GAP) begin
          m_busy   = 1'b0;
          m_active = 0;
        end
      end else if (|req) begin
        w = -1;
        for (int off = 0; off < N_REQ; off++) begin
          c = (int'(m_ptr) + off) % N_REQ;
          if ((w < 0) && req[c]) w = c;
        end
        exp_q.push_back({4'(w), data[w*SW +: SW]});
        m_ack[w] = 1'b1;
        m_cs_n   = 1'b0;
        m_busy   = 1'b1;
        m_cur    = 4'(w);
        m_ptr    = 4'((w + 1) % N_REQ);
        m_active = 1;
        m_t      = 0;
        m_clk    = 0;
      end
    end
  end

  // Monitor: per-cycle pin checks plus SPI decoding into the scoreboard.
  bit          mon_on = 0;
  int          mon_nbits = 0;
  int          mon_low = 0;
  int          mon_run = 0;
  int          mon_last_low = 0;
  int          mon_fall = 0;
  int          mon_prev_fall = 0;
  logic [15:0] mon_word = '0;
  logic [15:0] mon_last_word = '0;
  logic        p_cs_n = 1'b1;
  logic        p_sclk_n = 1'b1;

  always @(negedge clk) begin
    end_t e;
    if (mon_on) begin
      check("cs_n", cs_n, m_cs_n);
      check("busy", busy, m_busy);
      check("ack", ack, m_ack);
      check("cur_ch", cur_ch, m_cur);
      if (m_cs_n) begin
        check("sclk_n_idle", sclk_n, 1);
        check("mosi_idle", mosi, 0);
      end
      if (p_cs_n && !cs_n) begin
        mon_nbits     = 0;
        mon_word      = '0;
        mon_low       = 0;
        mon_prev_fall = mon_fall;
        mon_fall      = cyc;
      end
      if (!cs_n) mon_low++;
      if (!cs_n && p_sclk_n && !sclk_n) begin
        mon_word = {mon_word[14:0], mosi};
        mon_nbits++;
        mon_run = 0;
      end
      if (!sclk_n && m_en_last) mon_run++;
      if (!p_sclk_n && sclk_n && !m_rst_last) check("sclk_low_width", mon_run, DIV);
      if (!p_cs_n && cs_n) begin
        mon_last_low  = mon_low;
        mon_last_word = mon_word;
        if (end_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_end actual=unexpected_cs_rise required=no_frame t=%0t", $time);
        end else begin
          e = end_q.pop_front();
          check("cs_low_clk", mon_low, e.low_clk);
          if (e.full) begin
            check("nbits", mon_nbits, 16);
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_word actual=%0h required=none t=%0t", mon_word, $time);
            end else begin
              check("frame_word", mon_word, exp_q.pop_front());
            end
          end else begin
            check("aborted_short", mon_nbits < 16, 1);
          end
        end
      end
    end
    p_cs_n   = cs_n;
    p_sclk_n = sclk_n;
  end

  task automatic send_one(input int ch, input logic [11:0] s, input int bound, input bit must);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    req[ch] = 1'b1;
    data[ch*SW +: SW] = s;
    for (int i = 0; (i < bound) && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack[ch]) got = 1;
    end
    req[ch] = 1'b0;
    if (must) check("ack_seen", got, 1);
  endtask

  task automatic chan_proc(input int ch);
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 80)) @(posedge clk);
      if ($urandom_range(0, 3) == 0)
        send_one(ch, 12'($urandom), int'($urandom_range(1, 15)), 0);
      else
        send_one(ch, 12'($urandom), 900, 0);
      data[ch*SW +: SW] = 12'($urandom);
    end
  endtask

  bit rand_ena = 0;
  always @(posedge clk) begin
    if (rand_ena) begin
      #1;
      ena = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit hit;
    rst_a = 1'b1;
    ena   = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk_n", sclk_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;

    // Single frame from channel 2.
    send_one(2, 12'hABC, 20, 1);
    repeat (150) @(posedge clk);
    #1;
    check("single_word", mon_last_word, 16'h2ABC);
    check("single_low", mon_last_low, LOW_CYC);

    // Reset while idle, then all four requesting from pointer 0.
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    fork
      send_one(0, 12'($urandom), 700, 1);
      send_one(1, 12'($urandom), 700, 1);
      send_one(2, 12'($urandom), 700, 1);
      send_one(3, 12'($urandom), 700, 1);
    join
    check("b2b_period", mon_fall - mon_prev_fall, LOW_CYC + GAP + 1);
    repeat (150) @(posedge clk);

    // Channel 3 alone, with a short-lived channel 1 request during its frame.
    fork
      send_one(3, 12'($urandom), 20, 1);
      begin
        repeat (20) @(posedge clk);
        #1;
        req[1] = 1'b1;
        data[1*SW +: SW] = 12'($urandom);
        repeat (10) @(posedge clk);
        #1;
        req[1] = 1'b0;
      end
    join
    repeat (150) @(posedge clk);
    fork
      send_one(0, 12'($urandom), 400, 1);
      send_one(1, 12'($urandom), 400, 1);
    join
    repeat (150) @(posedge clk);

    // Clock-enable toggling every cycle through one frame.
    fork
      begin
        repeat (300) begin
          @(posedge clk);
          #1;
          ena = ~ena;
        end
        ena = 1'b1;
      end
      send_one(2, 12'h5A3, 10, 1);
    join
    repeat (20) @(posedge clk);
    #1;
    check("gated_low", mon_last_low, 2 * LOW_CYC);
    check("gated_word", mon_last_word, 16'h25A3);

    // Reset after the 8th sclk pulse.
    hit = 0;
    fork
      send_one(1, 12'($urandom), 20, 1);
      for (int i = 0; (i < 2000) && !hit; i++) begin
        @(posedge clk);
        #1;
        if ((mon_nbits == 8) && sclk_n && !cs_n) hit = 1;
      end
    join
    check("mid_frame_reached", hit, 1);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk_n", sclk_n, 1);
    check("midrst_mosi", mosi, 0);
    check("midrst_ack", ack, 0);
    repeat (200) @(posedge clk);

    // Random traffic with random enable and withdrawals.
    rand_ena = 1;
    fork
      chan_proc(0);
      chan_proc(1);
      chan_proc(2);
      chan_proc(3);
    join
    rand_ena = 0;
    @(posedge clk);
    #2;
    ena = 1'b1;
    for (int i = 0; (i < 3000) && m_active; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("end_q_drained", end_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
